addsub_seq: RTL

Parametrised multi-cycle two's-complement adder/subtractor with a runtime add/sub mode select. It processes operands CHUNK bits per clock from LSB to MSB, keeping the carry in a register between chunks. Operand input and result output each use a valid/ready handshake. It is the sequential successor to the team's 4-bit a + ~b + cin subtractor and serves as the shared arithmetic unit for wider datapaths.

---
 rtl/addsub_pkg.sv | 23 ++
 rtl/addsub_chunk.sv | 24 ++
 rtl/addsub_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential adder/subtractor.
// Holds the FSM state type, mode encodings and chunk-count helpers.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // An index register is always at least one bit wide, even for NCHUNK=1.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out.
// Ports: x, y, cin -> s, cout, c_msb (carry into the slice MSB).
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    always_comb begin
        full  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
        s     = full[CHUNK-1:0];
        cout  = full[CHUNK];
        // The sum bit is x^y^carry_in, so the carry into the MSB falls out.
        c_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ full[CHUNK-1];
    end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub, CHUNK bits per clock, LSB first, valid/ready on both sides.
// Ports: clk, rst, in_valid/in_ready, mode, a, b, out_valid/out_ready, sum, cout, ovf.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;

    int               off;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_ext;
    logic [CHUNK-1:0] cx;
    logic [CHUNK-1:0] cy;
    logic [CHUNK-1:0] cs;
    logic             cc;
    logic             cm;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Shifting the operands down selects the active chunk without
    // a variable part-select.
    always_comb begin
        off   = int'(idx) * CHUNK;
        a_sh  = a_reg >> off;
        b_sh  = b_reg >> off;
        cx    = a_sh[CHUNK-1:0];
        cy    = b_sh[CHUNK-1:0];
        s_ext = '0;
        s_ext[CHUNK-1:0] = cs;
    end

    addsub_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x    (cx),
        .y    (cy),
        .cin  (carry),
        .s    (cs),
        .cout (cc),
        .c_msb(cm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg <= a;
                        b_reg <= (mode == MODE_SUB) ? ~b : b;
                        carry <= mode;
                        idx   <= '0;
                        sum   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Result was cleared on accept, so OR-ing places the chunk.
                    sum   <= sum | (s_ext << off);
                    carry <= cc;
                    if (idx == LAST) begin
                        cout  <= cc;
                        ovf   <= cm ^ cc;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
